// File: rtl/param_alu.sv
// Parameterised ALU with a ready/valid request side and a held result register.
// Single-cycle ops finish in one cycle; MUL (shift-add) and DIV (restoring) iterate one bit per cycle.
module param_alu #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [3:0]           command,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 div_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_INC  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_DEC  = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_DIV  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_INV  = 4'd10;
    localparam logic [3:0] OP_NAND = 4'd11;
    localparam logic [3:0] OP_NOR  = 4'd12;
    localparam logic [3:0] OP_XOR  = 4'd13;
    localparam logic [3:0] OP_XNOR = 4'd14;
    localparam logic [3:0] OP_BUF  = 4'd15;

    localparam int CW = $clog2(WIDTH) + 1;

    logic [1:0]           state_reg, state_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [WIDTH-1:0]     hi_reg, hi_next;
    logic [WIDTH-1:0]     lo_reg, lo_next;
    logic [WIDTH-1:0]     opnd_reg, opnd_next;
    logic                 is_div_reg, is_div_next;
    logic [2*WIDTH-1:0]   out_reg, out_next;
    logic                 div_err_reg, div_err_next;

    logic                 accept;
    logic                 is_iter;
    logic [WIDTH-1:0]     op_b;
    logic [WIDTH:0]       add_w, sub_w;
    logic [WIDTH-1:0]     and_w, or_w, xor_w;
    logic [2*WIDTH-1:0]   alu_res;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH-1:0]     mul_hi, mul_lo;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_hi, div_lo;
    logic [WIDTH-1:0]     step_hi, step_lo;

    assign in_ready  = enable && (state_reg == ST_IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_reg == ST_HOLD);
    assign out       = out_reg;
    assign div_err   = div_err_reg;

    assign is_iter = (command == OP_MUL) || ((command == OP_DIV) && (b != '0));

    // Odd opcodes of the add/sub pair (INC, DEC) use a constant 1 as second operand.
    assign op_b  = command[0] ? WIDTH'(1) : b;
    assign add_w = {1'b0, a} + {1'b0, op_b};
    assign sub_w = {1'b0, a} - {1'b0, op_b};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bitwise
            assign and_w[gi] = a[gi] & b[gi];
            assign or_w[gi]  = a[gi] | b[gi];
            assign xor_w[gi] = a[gi] ^ b[gi];
        end
    endgenerate

    always_comb begin
        alu_res = '0;
        case (command)
            OP_ADD, OP_INC: alu_res = {{(WIDTH-1){1'b0}}, add_w};
            OP_SUB, OP_DEC: alu_res = {{(WIDTH-1){1'b0}}, sub_w};
            OP_DIV:         alu_res = '1;
            OP_SHL:         alu_res = {{(WIDTH-1){1'b0}}, a, 1'b0};
            OP_SHR:         alu_res = {{(WIDTH+1){1'b0}}, a[WIDTH-1:1]};
            OP_AND:         alu_res = {{WIDTH{1'b0}}, and_w};
            OP_OR:          alu_res = {{WIDTH{1'b0}}, or_w};
            OP_INV:         alu_res = {{WIDTH{1'b0}}, ~a};
            OP_NAND:        alu_res = {{WIDTH{1'b0}}, ~and_w};
            OP_NOR:         alu_res = {{WIDTH{1'b0}}, ~or_w};
            OP_XOR:         alu_res = {{WIDTH{1'b0}}, xor_w};
            OP_XNOR:        alu_res = {{WIDTH{1'b0}}, ~xor_w};
            OP_BUF:         alu_res = {{WIDTH{1'b0}}, a};
            default:        alu_res = '0;
        endcase
    end

    // hi/lo are shared: MUL keeps {partial product, multiplier}, DIV keeps {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
        mul_hi    = mul_sum[WIDTH:1];
        mul_lo    = {mul_sum[0], lo_reg[WIDTH-1:1]};
        div_shift = {hi_reg, lo_reg[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_reg});
        div_hi    = div_ge ? (div_shift[WIDTH-1:0] - opnd_reg) : div_shift[WIDTH-1:0];
        div_lo    = {lo_reg[WIDTH-2:0], div_ge};
        step_hi   = is_div_reg ? div_hi : mul_hi;
        step_lo   = is_div_reg ? div_lo : mul_lo;
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        opnd_next    = opnd_reg;
        is_div_next  = is_div_reg;
        out_next     = out_reg;
        div_err_next = div_err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (is_iter) begin
                        state_next  = ST_ITER;
                        cnt_next    = '0;
                        is_div_next = (command == OP_DIV);
                        hi_next     = '0;
                        lo_next     = (command == OP_DIV) ? a : b;
                        opnd_next   = (command == OP_DIV) ? b : a;
                    end else begin
                        state_next   = ST_HOLD;
                        out_next     = alu_res;
                        div_err_next = (command == OP_DIV);
                    end
                end
            end
            ST_ITER: begin
                hi_next  = step_hi;
                lo_next  = step_lo;
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    state_next   = ST_HOLD;
                    out_next     = {step_hi, step_lo};
                    div_err_next = 1'b0;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            opnd_reg    <= '0;
            is_div_reg  <= 1'b0;
            out_reg     <= '0;
            div_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            opnd_reg    <= opnd_next;
            is_div_reg  <= is_div_next;
            out_reg     <= out_next;
            div_err_reg <= div_err_next;
        end
    end

endmodule

// File: tb/tb_param_alu.sv
// Directed and randomized checks of param_alu against an arithmetic reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_param_alu;

    localparam int W = 8;

    logic             clk;
    logic             rst;
    logic             enable;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [3:0]       command;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out;
    logic             div_err;

    int checks = 0;
    int errors = 0;

    param_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .command   (command),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .div_err   (div_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {div_err, out} computed with plain integer arithmetic.
    function automatic logic [2*W:0] model(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
        longint ua;
        longint ub;
        longint m;
        longint r;
        logic   e;
        ua = longint'(x);
        ub = longint'(y);
        m  = longint'(1) << W;
        r  = 0;
        e  = 1'b0;
        case (c)
            4'd0:  r = ua + ub;
            4'd1:  r = ua + 1;
            4'd2:  r = (ua >= ub) ? ua - ub : ua - ub + 2 * m;
            4'd3:  r = (ua >= 1) ? ua - 1 : 2 * m - 1;
            4'd4:  r = ua * ub;
            4'd5:  begin
                if (ub == 0) begin
                    r = (longint'(1) << (2 * W)) - 1;
                    e = 1'b1;
                end else begin
                    r = (ua % ub) * m + ua / ub;
                end
            end
            4'd6:  r = ua * 2;
            4'd7:  r = ua / 2;
            4'd8:  r = ua & ub;
            4'd9:  r = ua | ub;
            4'd10: r = (~ua) & (m - 1);
            4'd11: r = (~(ua & ub)) & (m - 1);
            4'd12: r = (~(ua | ub)) & (m - 1);
            4'd13: r = ua ^ ub;
            4'd14: r = (~(ua ^ ub)) & (m - 1);
            default: r = ua;
        endcase
        return {e, r[2*W-1:0]};
    endfunction

    // Issues one op, checks latency, result, hold behaviour and release; called just after a falling edge.
    task automatic run_op(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int stall, input string tag, output logic [2*W-1:0] got);
        logic [2*W:0]   e;
        logic [2*W-1:0] held;
        int             lat;
        int             cyc;
        e   = model(c, x, y);
        lat = (c == 4'd4 || (c == 4'd5 && y != 0)) ? W + 1 : 1;
        command   = c;
        a         = x;
        b         = y;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        #1 check({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 4 * W) begin
            check({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
            a        = W'($urandom);
            b        = W'($urandom);
            command  = 4'($urandom);
            in_valid = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, 64'(cyc), 64'(lat));
        check({tag, "_out"}, 64'(out), 64'(e[2*W-1:0]));
        check({tag, "_div_err"}, 64'(div_err), 64'(e[2*W]));
        check({tag, "_in_ready_hold"}, 64'(in_ready), 64'd0);
        held = out;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            a        = W'($urandom);
            b        = W'($urandom);
            command  = 4'($urandom);
            @(negedge clk);
            check({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_stall_out"}, 64'(out), 64'(held));
            check({tag, "_stall_in_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_out_kept"}, 64'(out), 64'(held));
        check({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
        got = held;
    endtask

    initial begin
        logic [2*W-1:0] got;
        logic [3:0]     rc;
        logic [W-1:0]   rx;
        logic [W-1:0]   ry;

        rst       = 1'b1;
        enable    = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        a         = 8'd7;
        b         = 8'd3;
        command   = 4'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out", 64'(out), 64'd0);
        check("rst_div_err", 64'(div_err), 64'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1 check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        run_op(4'd0, 8'd20, 8'd10, 0, "add_20_10", got);
        check("add_20_10_lit", 64'(got), 64'h001E);
        run_op(4'd0, 8'd200, 8'd100, 0, "add_200_100", got);
        check("add_200_100_lit", 64'(got), 64'h012C);
        run_op(4'd2, 8'd10, 8'd20, 0, "sub_10_20", got);
        check("sub_10_20_lit", 64'(got), 64'h01F6);
        run_op(4'd3, 8'd0, 8'd0, 0, "dec_0", got);
        check("dec_0_lit", 64'(got), 64'h01FF);
        run_op(4'd6, 8'h81, 8'd0, 0, "shl_81", got);
        check("shl_81_lit", 64'(got), 64'h0102);
        run_op(4'd4, 8'd255, 8'd255, 0, "mul_255_255", got);
        check("mul_255_255_lit", 64'(got), 64'hFE01);
        run_op(4'd5, 8'd25, 8'd4, 0, "div_25_4", got);
        check("div_25_4_lit", 64'(got), 64'h0106);
        run_op(4'd13, 8'hA5, 8'h3C, 3, "xor_stall", got);
        run_op(4'd5, 8'd25, 8'd0, 0, "div_25_0", got);
        check("div_25_0_lit", 64'(got), 64'hFFFF);
        check("div_25_0_err_kept", 64'(div_err), 64'd1);

        // Reset during the 4th ITER cycle of a DIV discards it.
        command  = 4'd5;
        a        = 8'd25;
        b        = 8'd4;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1 check("mid_iter_rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("mid_iter_rst_out", 64'(out), 64'd0);
        check("mid_iter_rst_valid", 64'(out_valid), 64'd0);
        check("mid_iter_rst_div_err", 64'(div_err), 64'd0);
        rst = 1'b0;
        #1 check("mid_iter_post_rst_in_ready", 64'(in_ready), 64'd1);
        repeat (W + 2) @(negedge clk);
        check("mid_iter_discarded", 64'(out_valid), 64'd0);

        enable   = 1'b0;
        in_valid = 1'b1;
        #1 check("disabled_in_ready", 64'(in_ready), 64'd0);
        repeat (3) @(negedge clk);
        check("disabled_no_accept", 64'(out_valid), 64'd0);
        enable   = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            rc = 4'($urandom_range(0, 15));
            rx = W'($urandom);
            ry = ($urandom_range(0, 5) == 0) ? W'(0) : W'($urandom);
            run_op(rc, rx, ry, $urandom_range(0, 2), $sformatf("rnd%0d_op%0d", i, rc), got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
